// File: rtl/reg_read_stage.sv
// Register-read stage: NUM_REGS x DATA_W register file with write-back bypass,
// feeding a valid/ready operand slot that snoops write-backs while stalled.
module reg_read_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned IMM_W    = 9,
    parameter int unsigned CTRL_W   = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [1:0]        in_fmt,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic [ADDR_W-1:0] in_rc,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_op_c
);

    typedef enum logic [1:0] {
        FMT_NONE = 2'b00,
        FMT_J    = 2'b01,
        FMT_I    = 2'b10,
        FMT_R    = 2'b11
    } fmt_e;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] op_c_q, op_c_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] src_c_q, src_c_d;
    logic              b_reg_q, b_reg_d;
    logic              c_reg_q, c_reg_d;

    logic              accept;
    logic [DATA_W-1:0] rd_a, rd_b, rd_c;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_op_a  = op_a_q;
    assign out_op_b  = op_b_q;
    assign out_op_c  = op_c_q;

    // Same-cycle write-back is forwarded so the slot never captures a stale value.
    always_comb begin
        rd_a = (wb_en && wb_addr == in_ra) ? wb_data : rf_q[in_ra];
        rd_b = (wb_en && wb_addr == in_rb) ? wb_data : rf_q[in_rb];
        rd_c = (wb_en && wb_addr == in_rc) ? wb_data : rf_q[in_rc];
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end

        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        src_c_d     = src_c_q;
        b_reg_d     = b_reg_q;
        c_reg_d     = c_reg_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            op_a_d      = rd_a;
            op_b_d      = '0;
            op_c_d      = '0;
            src_a_d     = in_ra;
            src_b_d     = in_rb;
            src_c_d     = in_rc;
            b_reg_d     = 1'b0;
            c_reg_d     = 1'b0;
            case (fmt_e'(in_fmt))
                FMT_R: begin
                    op_b_d  = rd_b;
                    op_c_d  = rd_c;
                    b_reg_d = 1'b1;
                    c_reg_d = 1'b1;
                end
                FMT_I: begin
                    op_b_d  = rd_b;
                    op_c_d  = DATA_W'(in_imm[5:0]);
                    b_reg_d = 1'b1;
                end
                FMT_J: begin
                    op_c_d  = DATA_W'(in_imm);
                end
                default: ;
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wb_en) begin
            // Held slot tracks write-backs to its source registers.
            if (src_a_q == wb_addr) begin
                op_a_d = wb_data;
            end
            if (b_reg_q && src_b_q == wb_addr) begin
                op_b_d = wb_data;
            end
            if (c_reg_q && src_c_q == wb_addr) begin
                op_c_d = wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[ADDR_W'(i)] <= (i == NUM_REGS - 1) ? '0 : DATA_W'(i + 1);
            end
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            src_c_q     <= '0;
            b_reg_q     <= 1'b0;
            c_reg_q     <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            src_c_q     <= src_c_d;
            b_reg_q     <= b_reg_d;
            c_reg_q     <= c_reg_d;
        end
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus random traffic against a
// reference model that derives held operands from the current register contents.
module tb_reg_read_stage;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned IMM_W    = 9;
    localparam int unsigned CTRL_W   = 7;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [1:0]        in_fmt;
    logic [ADDR_W-1:0] in_ra, in_rb, in_rc;
    logic [IMM_W-1:0]  in_imm;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_op_a, out_op_b, out_op_c;

    reg_read_stage #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .IMM_W   (IMM_W),
        .CTRL_W  (CTRL_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_fmt   (in_fmt),
        .in_ra    (in_ra),
        .in_rb    (in_rb),
        .in_rc    (in_rc),
        .in_imm   (in_imm),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_op_a (out_op_a),
        .out_op_b (out_op_b),
        .out_op_c (out_op_c)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural registers plus the instruction sitting in the slot.
    logic [DATA_W-1:0] m_r [NUM_REGS];
    bit                m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [1:0]        m_fmt;
    logic [ADDR_W-1:0] m_ra, m_rb, m_rc;
    logic [IMM_W-1:0]  m_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_r[i] = (i == NUM_REGS - 1) ? 16'd0 : 16'(i + 1);
        end
        m_valid = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] exp_b();
        return m_fmt[1] ? m_r[m_rb] : 16'd0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_c();
        case (m_fmt)
            2'b11:   return m_r[m_rc];
            2'b10:   return {10'd0, m_imm[5:0]};
            2'b01:   return {7'd0, m_imm};
            default: return 16'd0;
        endcase
    endfunction

    task automatic check_slot();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        if (m_valid) begin
            chk("out_ctrl", {25'd0, out_ctrl}, {25'd0, m_ctrl});
            chk("op_a", {16'd0, out_op_a}, {16'd0, m_r[m_ra]});
            chk("op_b", {16'd0, out_op_b}, {16'd0, exp_b()});
            chk("op_c", {16'd0, out_op_c}, {16'd0, exp_c()});
        end
    endtask

    // Advance the model by one clock from the current inputs, then sample the DUT.
    task automatic tick();
        bit acc;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_ctrl  = in_ctrl;
            m_fmt   = in_fmt;
            m_ra    = in_ra;
            m_rb    = in_rb;
            m_rc    = in_rc;
            m_imm   = in_imm;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en) begin
            m_r[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        check_slot();
    endtask

    task automatic set_instr(input bit v, input logic [1:0] fmt, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [2:0] rc,
                             input logic [8:0] imm, input logic [6:0] ctrl);
        in_valid = v;
        in_fmt   = fmt;
        in_ra    = ra;
        in_rb    = rb;
        in_rc    = rc;
        in_imm   = imm;
        in_ctrl  = ctrl;
    endtask

    task automatic set_wb(input bit en, input logic [2:0] addr, input logic [15:0] data);
        wb_en   = en;
        wb_addr = addr;
        wb_data = data;
    endtask

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_instr(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 9'd0, 7'd0);
        set_wb(1'b0, 3'd0, 16'd0);
        model_reset();

        // Reset state
        #11;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", {16'd0, out_op_a}, 32'd0);
        chk("rst_op_b", {16'd0, out_op_b}, 32'd0);
        chk("rst_op_c", {16'd0, out_op_c}, 32'd0);
        chk("rst_ctrl", {25'd0, out_ctrl}, 32'd0);
        resetn = 1'b1;

        // R-format from the reset image
        out_ready = 1'b1;
        set_instr(1'b1, 2'b11, 3'd0, 3'd1, 3'd2, 9'd0, 7'h11);
        tick();
        chk("r_valid", {31'd0, out_valid}, 32'd1);
        chk("r_op_a", {16'd0, out_op_a}, 32'h1);
        chk("r_op_b", {16'd0, out_op_b}, 32'h2);
        chk("r_op_c", {16'd0, out_op_c}, 32'h3);

        // I-format with same-cycle write-back bypass
        set_instr(1'b1, 2'b10, 3'd3, 3'd4, 3'd0, 9'h1FF, 7'h22);
        set_wb(1'b1, 3'd3, 16'hBEEF);
        tick();
        chk("i_op_a", {16'd0, out_op_a}, 32'hBEEF);
        chk("i_op_b", {16'd0, out_op_b}, 32'h5);
        chk("i_op_c", {16'd0, out_op_c}, 32'h3F);
        set_wb(1'b0, 3'd0, 16'd0);

        // J-format and no-operand format
        set_instr(1'b1, 2'b01, 3'd0, 3'd4, 3'd5, 9'h155, 7'h33);
        tick();
        chk("j_op_b", {16'd0, out_op_b}, 32'h0);
        chk("j_op_c", {16'd0, out_op_c}, 32'h155);
        set_instr(1'b1, 2'b00, 3'd1, 3'd4, 3'd5, 9'h0AA, 7'h44);
        tick();
        chk("n_op_b", {16'd0, out_op_b}, 32'h0);
        chk("n_op_c", {16'd0, out_op_c}, 32'h0);

        // Stall with snoop of a held operand
        set_instr(1'b1, 2'b11, 3'd0, 3'd6, 3'd2, 9'd0, 7'h55);
        tick();
        chk("st_op_b0", {16'd0, out_op_b}, 32'h7);
        out_ready = 1'b0;
        set_instr(1'b1, 2'b00, 3'd1, 3'd1, 3'd1, 9'd1, 7'h66);
        tick();
        chk("st_ready1", {31'd0, in_ready}, 32'd0);
        set_wb(1'b1, 3'd6, 16'h1234);
        tick();
        chk("st_ready2", {31'd0, in_ready}, 32'd0);
        chk("st_valid", {31'd0, out_valid}, 32'd1);
        chk("st_snoop_b", {16'd0, out_op_b}, 32'h1234);
        chk("st_ctrl", {25'd0, out_ctrl}, 32'h55);
        set_wb(1'b0, 3'd0, 16'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("st_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream, no bubbles
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, 2'b11, 3'(i), 3'(i + 1), 3'(i + 2), 9'(i), 7'(8 + i));
            tick();
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_ctrl", {25'd0, out_ctrl}, 32'(8 + i));
        end

        // Flush drops the slot and the incoming instruction but commits write-back
        flush = 1'b1;
        set_instr(1'b1, 2'b11, 3'd1, 3'd2, 3'd3, 9'd0, 7'h77);
        set_wb(1'b1, 3'd5, 16'd7);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        set_wb(1'b0, 3'd0, 16'd0);
        set_instr(1'b1, 2'b10, 3'd5, 3'd0, 3'd0, 9'd0, 7'h01);
        tick();
        chk("fl_r5", {16'd0, out_op_a}, 32'd7);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            set_instr($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 3'($urandom),
                      3'($urandom), 9'($urandom), 7'($urandom));
            set_wb($urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            tick();
        end

        // Asynchronous reset while the slot is stalled
        flush     = 1'b0;
        out_ready = 1'b1;
        set_wb(1'b0, 3'd0, 16'd0);
        set_instr(1'b1, 2'b01, 3'd2, 3'd0, 3'd0, 9'h1AB, 7'h5A);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        chk("ar_held", {31'd0, out_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_op_a", {16'd0, out_op_a}, 32'd0);
        chk("ar_op_c", {16'd0, out_op_c}, 32'd0);
        chk("ar_ctrl", {25'd0, out_ctrl}, 32'd0);
        model_reset();
        #2;
        resetn    = 1'b1;
        out_ready = 1'b1;
        set_instr(1'b1, 2'b11, 3'd7, 3'd0, 3'd1, 9'd0, 7'h02);
        tick();
        chk("ar_r7", {16'd0, out_op_a}, 32'd0);
        chk("ar_r0", {16'd0, out_op_b}, 32'd1);
        chk("ar_r1", {16'd0, out_op_c}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
